// File: rtl/mod16_seq_pkg.sv
// mod16_seq_pkg: shared state and mode codes for the mod-16 count sequencer
package mod16_seq_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/mod16_step_counter.sv
// mod16_step_counter: count register with enable, clear and terminal compare
module mod16_step_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] tc,
    output logic [WIDTH-1:0] q,
    output logic             at_tc
);
    assign at_tc = q == tc;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (clr) q <= '0;
        else if (en) q <= q + 1'b1;
endmodule

// File: rtl/mod16_count_sequencer.sv
// mod16_count_sequencer: run-control FSM, prescaler and shadow registers driving the step counter
module mod16_count_sequencer
    import mod16_seq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      tc,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  done
);
    state_t                state;
    logic [WIDTH-1:0]      tc_s;
    logic [PRESCALE_W-1:0] pre_s;
    logic [PRESCALE_W-1:0] pcnt;
    logic                  mode_s;
    logic                  active, launch, tick, step, at_tc, terminal;
    assign active   = state != ST_IDLE;
    assign launch   = !active && start && !stop;
    // a HOLD edge with pause low counts like a RUN edge, so a pause costs exactly its high cycles
    assign tick     = active && !stop && !pause;
    assign step     = tick && pcnt == pre_s;
    assign terminal = step && at_tc;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= ST_IDLE;
            tc_s   <= '0;
            pre_s  <= '0;
            mode_s <= MODE_ONESHOT;
            pcnt   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= terminal;
            if (launch) begin
                tc_s   <= tc;
                pre_s  <= prescale;
                mode_s <= mode;
                pcnt   <= '0;
                state  <= ST_RUN;
                busy   <= 1'b1;
            end else if (active && stop) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (active && pause) begin
                state <= ST_HOLD;
            end else if (active) begin
                state <= ST_RUN;
                pcnt  <= step ? '0 : pcnt + 1'b1;
                if (terminal && mode_s == MODE_ONESHOT) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    mod16_step_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step && !at_tc),
        .clr   (launch || (terminal && mode_s == MODE_PERIODIC)),
        .tc    (tc_s),
        .q     (q),
        .at_tc (at_tc)
    );
endmodule

// File: tb/tb_mod16_count_sequencer.sv
// tb_mod16_count_sequencer: directed literal checks plus randomized run against an arithmetic model
module tb_mod16_count_sequencer;
    logic       clk, rst_n, start, stop, pause, mode;
    logic [3:0] tc, prescale, q;
    logic       busy, done;
    int         checks = 0, errors = 0;
    // model: progress is the number of counting edges e since launch
    int         e_m, q_m, tc_m, p_m;
    bit         busy_m, done_m, mode_m;

    mod16_count_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .tc(tc), .prescale(prescale), .q(q), .busy(busy), .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        int per, steps;
        bit term;
        if (!rst_n) begin
            busy_m <= 0; done_m <= 0; q_m <= 0; e_m <= 0;
        end else begin
            done_m <= 0;
            if (!busy_m) begin
                if (start && !stop) begin
                    busy_m <= 1; tc_m <= int'(tc); p_m <= int'(prescale); mode_m <= mode;
                    e_m <= 0; q_m <= 0;
                end
            end else if (stop) begin
                busy_m <= 0;
            end else if (!pause) begin
                per   = (tc_m + 1) * (p_m + 1);
                term  = ((e_m + 1) % per) == 0;
                steps = (e_m + 1) / (p_m + 1);
                e_m    <= e_m + 1;
                done_m <= term;
                q_m    <= (term && !mode_m) ? tc_m : steps % (tc_m + 1);
                if (term && !mode_m) busy_m <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rst_n) begin
            chk("model_q", int'(q), q_m);
            chk("model_busy", int'(busy), int'(busy_m));
            chk("model_done", int'(done), int'(done_m));
        end
    endtask

    task automatic go(input bit m, input int t, input int p);
        mode = m; tc = 4'(t); prescale = 4'(p); start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        int first, second, dedge;
        rst_n = 0; start = 0; stop = 0; pause = 0; mode = 0; tc = 0; prescale = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        // one-shot TC=3 PRESCALE=0
        go(0, 3, 0);
        chk("os_busy0", int'(busy), 1);
        chk("os_q0", int'(q), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("os_q", int'(q), i);
            chk("os_nodone", int'(done), 0);
        end
        tick();
        chk("os_done", int'(done), 1);
        chk("os_qhold", int'(q), 3);
        chk("os_idle", int'(busy), 0);
        tick();
        chk("os_done_pulse", int'(done), 0);

        // asynchronous reset mid-sequence at Q=5
        go(0, 9, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("rst_pre_q", int'(q), 5);
        #2 rst_n = 0;
        #1;
        chk("rst_async_q", int'(q), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // periodic TC=15 PRESCALE=1
        go(1, 15, 1);
        first = -1; second = -1;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 31) chk("per_q15", int'(q), 15);
            if (i == 32) chk("per_wrap", int'(q), 0);
            if (done && first < 0) first = i;
            else if (done && second < 0) second = i;
        end
        chk("per_first_done", first, 32);
        chk("per_second_done", second, 64);
        chk("per_busy", int'(busy), 1);
        stop = 1; tick(); stop = 0;
        chk("per_stopped", int'(busy), 0);

        // periodic TC=9 PRESCALE=0, pause three cycles at Q=4
        go(1, 9, 0);
        for (int i = 1; i <= 4; i++) tick();
        chk("pz_q4", int'(q), 4);
        pause = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pz_hold_q", int'(q), 4);
            chk("pz_hold_busy", int'(busy), 1);
        end
        pause = 0;
        dedge = -1;
        for (int i = 8; i <= 20 && dedge < 0; i++) begin
            tick();
            if (done) dedge = i;
        end
        chk("pz_done_edge", dedge, 13);
        stop = 1; tick(); stop = 0;

        // STOP and START together in IDLE, then STOP mid-run
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        chk("ss_idle", int'(busy), 0);
        go(0, 9, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("stop_pre_q", int'(q), 6);
        stop = 1; tick(); stop = 0;
        chk("stop_idle", int'(busy), 0);
        chk("stop_q", int'(q), 6);
        chk("stop_nodone", int'(done), 0);
        tick();
        chk("stop_nodone2", int'(done), 0);
        go(0, 9, 0);
        chk("restart_q", int'(q), 0);
        chk("restart_busy", int'(busy), 1);
        stop = 1; tick(); stop = 0;

        // one-shot TC=0 PRESCALE=3, TC input changed during the run
        go(0, 0, 3);
        tc = 4'd7;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("tc0_q", int'(q), 0);
            chk("tc0_nodone", int'(done), 0);
        end
        tick();
        chk("tc0_done", int'(done), 1);
        chk("tc0_qend", int'(q), 0);
        chk("tc0_idle", int'(busy), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start    = $urandom_range(0, 7) == 0;
            stop     = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 9) == 0) pause = !pause;
            mode     = 1'($urandom_range(0, 1));
            tc       = 4'($urandom_range(0, 15));
            prescale = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 0;
                #1;
                chk("rand_async_q", int'(q), 0);
                @(negedge clk);
                rst_n = 1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
